// File: rtl/scp_pkg.sv
// rtl/scp_pkg.sv - opcodes, instruction field layout and FSM encoding for the SCP ALU core
package scp_pkg;

    localparam logic [3:0] OP_NOOP = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OP_LSB  = 28;
    localparam int RD_LSB  = 24;
    localparam int RS_LSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int IMM_LSB = 0;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    // Field order mirrors the bit positions above, msb first.
    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [15:0] imm;
    } instr_t;

    function automatic logic [31:0] scp_enc(logic [3:0] op, logic [3:0] rd, logic [3:0] rs,
                                            logic [3:0] rt, logic [15:0] imm);
        return {op, rd, rs, rt, imm};
    endfunction

endpackage

// File: rtl/scp_alu_core_if.sv
// rtl/scp_alu_core_if.sv - instruction memory fetch bus (combinational read)
interface scp_alu_core_if #(
    parameter int PC_W = 8
);
    logic [PC_W-1:0] instr_addr;
    logic [31:0]     instr;

    modport master (output instr_addr, input instr);
    modport slave  (input instr_addr, output instr);
endinterface

// File: rtl/scp_regfile.sv
// rtl/scp_regfile.sv - NREGS x WIDTH register file, two operand reads, one debug read, one write
module scp_regfile #(
    parameter  int WIDTH = 16,
    parameter  int NREGS = 8,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [RW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [RW-1:0]    ra0,
    output logic [WIDTH-1:0] rd0,
    input  logic [RW-1:0]    ra1,
    output logic [WIDTH-1:0] rd1,
    input  logic [RW-1:0]    dbg_sel,
    output logic [WIDTH-1:0] dbg_data
);

    logic [WIDTH-1:0] regs [NREGS];

    // r0 is never written, so it holds its reset value; reads still force zero explicitly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd0      = (ra0 == '0)     ? '0 : regs[ra0];
    assign rd1      = (ra1 == '0)     ? '0 : regs[ra1];
    assign dbg_data = (dbg_sel == '0) ? '0 : regs[dbg_sel];

endmodule

// File: rtl/scp_alu_core.sv
// rtl/scp_alu_core.sv - single-cycle SCP core: fetch, decode, ALU, PC, retire counter, halt FSM
// Optional SCP_OVF_EN adds a sticky signed-overflow flag output ovf.
module scp_alu_core
    import scp_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int NREGS = 8,
    parameter  int PC_W  = 8,
    parameter  int CNT_W = 16,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    scp_alu_core_if.master    imem,
    output logic              halted,
    output logic [CNT_W-1:0]  retired,
    input  logic [RW-1:0]     dbg_sel,
    output logic [WIDTH-1:0]  dbg_data
`ifdef SCP_OVF_EN
    ,
    output logic              ovf
`endif
);

    localparam int              MSB     = WIDTH - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [0:0]       state;
    logic [PC_W-1:0]  pc;
    instr_t           d;
    logic [RW-1:0]    rd_a, rs_a, rt_a;
    logic [WIDTH-1:0] rs_val, rt_val, imm_ext, result;
    logic             wr, is_halt, running, wen;
    logic             unused_fields;

    assign imem.instr_addr = pc;
    assign d               = instr_t'(imem.instr);
    assign rd_a            = d.rd[RW-1:0];
    assign rs_a            = d.rs[RW-1:0];
    assign rt_a            = d.rt[RW-1:0];
    assign unused_fields   = ^{d.rd, d.rs, d.rt, d.imm};

    generate
        if (WIDTH > 16) begin : g_sext
            assign imm_ext = {{(WIDTH - 16){d.imm[15]}}, d.imm};
        end else begin : g_trunc
            assign imm_ext = d.imm[WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        result  = '0;
        wr      = 1'b0;
        is_halt = 1'b0;
        case (d.op)
            OP_ADD:  begin result = rs_val + rt_val;  wr = 1'b1; end
            OP_SUB:  begin result = rs_val - rt_val;  wr = 1'b1; end
            OP_AND:  begin result = rs_val & rt_val;  wr = 1'b1; end
            OP_OR:   begin result = rs_val | rt_val;  wr = 1'b1; end
            OP_ADDI: begin result = rs_val + imm_ext; wr = 1'b1; end
            OP_HALT: is_halt = 1'b1;
            default: ;
        endcase
    end

    assign running = (state == ST_RUN);
    assign wen     = wr && running;
    assign halted  = (state == ST_HALT);

    scp_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (wen),
        .wa       (rd_a),
        .wd       (result),
        .ra0      (rs_a),
        .rd0      (rs_val),
        .ra1      (rt_a),
        .rd1      (rt_val),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    // HALT itself neither advances the PC nor counts as retired.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_RUN;
            pc      <= '0;
            retired <= '0;
        end else if (running) begin
            if (is_halt) begin
                state <= ST_HALT;
            end else begin
                pc <= pc + 1'b1;
                if (retired != CNT_MAX) begin
                    retired <= retired + 1'b1;
                end
            end
        end
    end

`ifdef SCP_OVF_EN
    logic ovf_hit;

    always_comb begin
        ovf_hit = 1'b0;
        case (d.op)
            OP_ADD:  ovf_hit = (rs_val[MSB] == rt_val[MSB])  && (result[MSB] != rs_val[MSB]);
            OP_SUB:  ovf_hit = (rs_val[MSB] != rt_val[MSB])  && (result[MSB] != rs_val[MSB]);
            OP_ADDI: ovf_hit = (rs_val[MSB] == imm_ext[MSB]) && (result[MSB] != rs_val[MSB]);
            default: ovf_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (running && ovf_hit) begin
            ovf <= 1'b1;
        end
    end
`endif

endmodule
